// File: rtl/multi_clock_divider.sv
// ---------------------------------------------------------------------------
// multi_clock_divider
//   NUM_CH independent clock-enable generators. Each channel produces a
//   one-cycle tick strobe every De clk cycles and a 50%-duty square wave that
//   toggles on every tick. De is the channel's active divisor, where 0 is
//   treated as 1. Divisors are runtime-programmable. A write to a running
//   channel is parked until the current period ends, so the output never
//   glitches.
//
// Ports
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset
//   en          per-channel count enable
//   sync        one-cycle pulse, restarts every channel in phase
//   cfg_we      divisor write strobe
//   cfg_ch      channel index for the write (indices >= NUM_CH are ignored)
//   cfg_div     new divisor value
//   tick        registered one-cycle strobe per period, per channel
//   sq          registered square wave, per channel
//   div_active  divisor in use; channel i at [i*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module multi_clock_divider #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 30,
  parameter int DEFAULT_DIV = 5000000,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic                    sync,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [CNT_W-1:0]        cfg_div,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       sq,
  output logic [NUM_CH*CNT_W-1:0] div_active
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] count_r, count_s;
    logic [CNT_W-1:0] div_act_r, div_act_s;
    logic [CNT_W-1:0] div_pend_r, div_pend_s;
    logic             pend_valid_r, pend_valid_s;
    logic             tick_r, tick_s;
    logic             sq_r, sq_s;
    logic             wr_s;
    logic             terminal_s;
    logic [CNT_W-1:0] div_eff_s;

    // Out-of-range indices never match any generated channel, so they are
    // dropped without an explicit range check.
    assign wr_s       = cfg_we && (cfg_ch == CH_W'(i));
    assign div_eff_s  = (div_act_r == ZERO) ? ONE : div_act_r;
    // ">=" keeps the channel from running away if count ever exceeded De-1.
    assign terminal_s = (count_r >= (div_eff_s - ONE));

    // Next-state logic for one channel, in edge priority order.
    always_comb begin
      count_s      = count_r;
      div_act_s    = div_act_r;
      div_pend_s   = div_pend_r;
      pend_valid_s = pend_valid_r;
      tick_s       = 1'b0;
      sq_s         = sq_r;
      if (sync) begin
        count_s      = ZERO;
        sq_s         = 1'b0;
        pend_valid_s = 1'b0;
        // A same-cycle write beats an older pending value.
        if (wr_s) begin
          div_act_s = cfg_div;
        end else if (pend_valid_r) begin
          div_act_s = div_pend_r;
        end else begin
          div_act_s = div_act_r;
        end
      end else if (wr_s && !en[i]) begin
        // An idle channel can take the new divisor at once and restart.
        div_act_s    = cfg_div;
        count_s      = ZERO;
        pend_valid_s = 1'b0;
      end else if (en[i]) begin
        if (terminal_s) begin
          count_s = ZERO;
          tick_s  = 1'b1;
          sq_s    = ~sq_r;
          if (pend_valid_r) begin
            div_act_s    = div_pend_r;
            pend_valid_s = 1'b0;
          end else begin
            div_act_s = div_act_r;
          end
        end else begin
          count_s = count_r + ONE;
        end
        // This follows the boundary promotion above. A write on the terminal
        // edge is therefore parked for the following period.
        if (wr_s) begin
          div_pend_s   = cfg_div;
          pend_valid_s = 1'b1;
        end else begin
          div_pend_s = div_pend_r;
        end
      end else begin
        tick_s = 1'b0;
      end
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        count_r      <= ZERO;
        div_act_r    <= DEF_DIV;
        div_pend_r   <= ZERO;
        pend_valid_r <= 1'b0;
        tick_r       <= 1'b0;
        sq_r         <= 1'b0;
      end else begin
        count_r      <= count_s;
        div_act_r    <= div_act_s;
        div_pend_r   <= div_pend_s;
        pend_valid_r <= pend_valid_s;
        tick_r       <= tick_s;
        sq_r         <= sq_s;
      end
    end

    assign tick[i]                        = tick_r;
    assign sq[i]                          = sq_r;
    assign div_active[i*CNT_W +: CNT_W]   = div_act_r;
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// ---------------------------------------------------------------------------
// tb_multi_clock_divider
//   Directed scenarios plus a randomized run. The reference model tracks each
//   channel's position within its period, its divisor and pending divisor,
//   and the number of ticks since the last restart. sq is the parity of that
//   tick count. The model advances on every posedge, and a single negedge
//   process compares all outputs against it. Each directed scenario also
//   checks tick and sq traces against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_multi_clock_divider;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 30;
  localparam int DEF    = 12;
  localparam int CH_W   = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       en;
  logic                    sync;
  logic                    cfg_we;
  logic [CH_W-1:0]         cfg_ch;
  logic [CNT_W-1:0]        cfg_div;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       sq;
  logic [NUM_CH*CNT_W-1:0] div_active;

  multi_clock_divider #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .tick(tick), .sq(sq),
    .div_active(div_active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Reference model state, one entry per channel.
  longint m_pos [NUM_CH];   // cycles elapsed in the current period
  longint m_div [NUM_CH];
  longint m_pend[NUM_CH];
  bit     m_pv  [NUM_CH];
  bit     m_tick[NUM_CH];
  int     m_nt  [NUM_CH];   // ticks since the last reset or sync

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      m_pos[i] = 0; m_div[i] = DEF; m_pend[i] = 0;
      m_pv[i] = 1'b0; m_tick[i] = 1'b0; m_nt[i] = 0;
    end
  end

  task automatic model_step();
    for (int i = 0; i < NUM_CH; i++) begin
      bit     wr;
      longint de;
      wr = cfg_we && (int'(cfg_ch) == i);
      if (rst) begin
        m_pos[i] = 0; m_div[i] = DEF; m_pv[i] = 1'b0; m_tick[i] = 1'b0; m_nt[i] = 0;
      end else if (sync) begin
        m_pos[i] = 0; m_tick[i] = 1'b0; m_nt[i] = 0;
        if (wr) m_div[i] = cfg_div;
        else if (m_pv[i]) m_div[i] = m_pend[i];
        m_pv[i] = 1'b0;
      end else if (wr && !en[i]) begin
        m_div[i] = cfg_div; m_pos[i] = 0; m_pv[i] = 1'b0; m_tick[i] = 1'b0;
      end else if (en[i]) begin
        de = (m_div[i] == 0) ? 1 : m_div[i];
        if (m_pos[i] + 1 >= de) begin
          m_pos[i] = 0; m_tick[i] = 1'b1; m_nt[i] = m_nt[i] + 1;
          if (m_pv[i]) begin
            m_div[i] = m_pend[i]; m_pv[i] = 1'b0;
          end
        end else begin
          m_pos[i] = m_pos[i] + 1; m_tick[i] = 1'b0;
        end
        if (wr) begin
          m_pend[i] = cfg_div; m_pv[i] = 1'b1;
        end
      end else begin
        m_tick[i] = 1'b0;
      end
    end
  endtask

  logic [NUM_CH-1:0]       exp_tick;
  logic [NUM_CH-1:0]       exp_sq;
  logic [NUM_CH*CNT_W-1:0] exp_div;

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < NUM_CH; i++) begin
        exp_tick[i] = m_tick[i];
        exp_sq[i]   = (m_nt[i] % 2) == 1;
        exp_div[i*CNT_W +: CNT_W] = CNT_W'(m_div[i]);
      end
      n_cmp++;
      if (tick !== exp_tick) begin
        n_bad++;
        $display("FAIL model_tick t=%0t: got %b expected %b", $time, tick, exp_tick);
      end
      n_cmp++;
      if (sq !== exp_sq) begin
        n_bad++;
        $display("FAIL model_sq t=%0t: got %b expected %b", $time, sq, exp_sq);
      end
      n_cmp++;
      if (div_active !== exp_div) begin
        n_bad++;
        $display("FAIL model_div t=%0t: got %h expected %h", $time, div_active, exp_div);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic write_div(input int ch, input int d);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_div = CNT_W'(d);
    step();
    cfg_we = 1'b0;
  endtask

  function automatic logic [CNT_W-1:0] div_of(input int ch);
    return div_active[ch*CNT_W +: CNT_W];
  endfunction

  logic [11:0] rec12;
  logic [9:0]  rec10;
  logic [7:0]  t0, s0, t1, s1, r8;
  logic [4:0]  r0;
  logic [3:0]  r3;
  logic [12:0] r13;
  int          cnt;

  initial begin
    rst = 1'b1; en = '0; sync = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;

    // Reset held for three cycles, then released with all channels idle.
    step(); chk_on = 1'b1;
    steps(2);
    rst = 1'b0;
    step();
    chk("rst_tick", tick, 64'd0);
    chk("rst_sq", sq, 64'd0);
    for (int c = 0; c < NUM_CH; c++) chk("rst_div", div_of(c), 64'(DEF));
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (tick != '0) cnt++;
    end
    chk("idle_ticks", cnt, 64'd0);

    // Basic divide by 4 on ch0.
    write_div(0, 4);
    en[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step(); rec12[k] = tick[0];
    end
    chk("basic_tick", rec12, 64'h888);
    chk("basic_sq", sq[0], 64'd1);

    // Reprogram ch1 from 6 to 3 while count is 2.
    write_div(1, 6);
    en[1] = 1'b1;
    steps(2);
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = CNT_W'(3);
    step(); cfg_we = 1'b0;
    rec10[0] = tick[1];
    for (int j = 1; j < 10; j++) begin
      step(); rec10[j] = tick[1];
      if (j == 2) chk("reprog_old_div", div_of(1), 64'd6);
      if (j == 3) chk("reprog_new_div", div_of(1), 64'd3);
    end
    chk("reprog_tick", rec10, 64'h248);

    // Divisors 0 and 1 on ch2 produce identical traces.
    write_div(2, 0);
    en[2] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(); t0[k] = tick[2]; s0[k] = sq[2];
    end
    en[2] = 1'b0;
    write_div(2, 1);
    en[2] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(); t1[k] = tick[2]; s1[k] = sq[2];
    end
    en[2] = 1'b0;
    chk("d0_tick", t0, 64'hFF);
    chk("d0_sq", s0, 64'h55);
    chk("d1_tick", t1, 64'hFF);
    chk("d1_sq", s1, 64'h55);
    chk("d0_d1_same", {t0, s0}, {t1, s1});

    // Sync with a same-cycle write, then an enable gap on ch0.
    en[0] = 1'b0;
    write_div(0, 5);
    write_div(3, 7);
    en[0] = 1'b1; en[3] = 1'b1;
    steps(3);
    sync = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = CNT_W'(2);
    step();
    sync = 1'b0; cfg_we = 1'b0;
    chk("sync_sq", {sq[3], sq[0]}, 64'd0);
    chk("sync_tick", {tick[3], tick[0]}, 64'd0);
    chk("sync_div3", div_of(3), 64'd2);
    chk("sync_div0", div_of(0), 64'd5);
    for (int k = 0; k < 5; k++) begin
      step(); r0[k] = tick[0];
      if (k < 4) r3[k] = tick[3];
    end
    chk("sync_ch0", r0, 64'h10);
    chk("sync_ch3", r3, 64'hA);
    en[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) en[0] = 1'b1;
      step(); r8[k] = tick[0];
    end
    chk("en_gap", r8, 64'h80);

    // Reset with a pending write on ch1 discards that write.
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = CNT_W'(9);
    step(); cfg_we = 1'b0;
    en = 4'hF;
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    chk("rst_mid_div", div_of(1), 64'(DEF));
    for (int k = 0; k < 13; k++) begin
      step(); r13[k] = tick[1];
    end
    chk("rst_first_tick", r13, 64'h800);
    chk("rst_mid_div_after", div_of(1), 64'(DEF));

    // Randomized traffic checked by the model.
    for (int k = 0; k < 3000; k++) begin
      rst     = ($urandom_range(0, 999) == 0);
      sync    = ($urandom_range(0, 49) == 0);
      cfg_we  = ($urandom_range(0, 9) == 0);
      cfg_ch  = CH_W'($urandom_range(0, NUM_CH - 1));
      cfg_div = CNT_W'($urandom_range(0, 9));
      for (int i = 0; i < NUM_CH; i++) en[i] = ($urandom_range(0, 99) < 85);
      step();
    end
    rst = 1'b0; sync = 1'b0; cfg_we = 1'b0;
    step();
    chk_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multi_clock_divider.md
# multi_clock_divider

Parametrised, multi-channel successor to the team's fixed single-output clock divider. Each of NUM_CH independent channels derives a one-cycle tick strobe and a 50%-duty square wave from the system clock. Each channel's divisor is runtime-programmable, changes glitch-free at a period boundary, and the channel has its own enable; a global sync input realigns all channels. The block sits beside the top-level clock and feeds game-logic timers, debouncers and display scan logic as clock-enable strobes.

## Interface
- NUM_CH, 4: number of independent channels (1..16).
- CNT_W, 30: counter and divisor width in bits.
- DEFAULT_DIV, 5000000: divisor loaded into every channel at reset (tick every 5,000,000 clk).
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- en  input  NUM_CH  per-channel count enable.
- sync  input  1  one-cycle pulse; restarts all channels in phase.
- cfg_we  input  1  divisor write strobe.
- cfg_ch  input  $clog2(NUM_CH) (min 1)  channel index for the write; indices >= NUM_CH are ignored.
- cfg_div  input  CNT_W  new divisor D.
- tick  output  NUM_CH  registered one-cycle strobe per period.
- sq  output  NUM_CH  registered square wave, toggles on every tick.
- div_active  output  NUM_CH*CNT_W  divisor currently in use; channel i occupies bits [i*CNT_W +: CNT_W].

## Operation
- Per-channel state: count, div_act, div_pend, pend_valid, tick, sq.
- Effective divisor: De = (div_act == 0) ? 1 : div_act. D = 0 behaves exactly as D = 1.
- Counting (en[i] = 1): count steps 0 .. De-1. At count == De-1 (terminal), the next edge sets count to 0, tick to 1 and toggles sq. Otherwise count increments and tick is 0.
- Tick period is De cycles; sq period is 2*De cycles at 50% duty. For De = 1, tick stays high continuously and sq toggles every cycle.
- Disabled (en[i] = 0): count and sq hold their values; tick is 0.
- Divisor write (cfg_we with a valid cfg_ch):
  - If the channel is disabled, the value goes directly to div_act and count clears to 0.
  - If the channel is enabled, the value goes to div_pend and pend_valid is set. At the next terminal edge, div_act takes div_pend and pend_valid clears. The current period always completes with the old divisor.
  - A second write before the boundary overwrites div_pend; the last write wins.
- Write on the terminal edge itself: the new value lands in div_pend and takes effect at the following boundary. The boundary currently happening uses the old div_pend, if one was valid.
- sync: on that edge, every channel sets count to 0, tick to 0 and sq to 0. Any pending divisor is promoted to div_act. A cfg_we in the same cycle is promoted as well, so the written value is active immediately.
- Priority per edge: rst > sync > cfg write to a disabled channel > terminal wrap > increment/hold.

## Timing
- Reset values: count 0, tick 0, sq 0, div_act = DEFAULT_DIV, pend_valid 0, div_active = DEFAULT_DIV on every channel.
- Reset mid-operation discards all pending writes and phase.
- Latency: with en high from the edge that clears rst, the first tick is high in the cycle following edge De. Later ticks follow every De cycles.
- tick and sq are registers: no combinational path from any input to any output.
- div_active updates on the same edge that div_act changes.
- Deasserting en on a terminal cycle suppresses the wrap. The count stays at De-1, and the wrap occurs on the first enabled edge after en returns.

## Test plan
- Reset: hold rst 3 cycles, then release with en = 0 -> tick = 0, sq = 0, div_active = DEFAULT_DIV on all channels; no ticks for 20 cycles.
- Basic divide: write D = 4 to ch0 while disabled, then set en[0] = 1 -> tick[0] high in cycles 4, 8, 12, … after enable; sq[0] toggles at those same cycles (period 8); other channels stay idle.
- Glitch-free reprogram: ch1 running with D = 6, write D = 3 at count 2 -> next tick still 4 cycles later, then every 3 cycles; div_active changes at that tick edge.
- Boundary divisors: D = 0 and D = 1 on ch2 -> tick continuously high, sq toggles every cycle, identical traces for both values.
- Sync and enable: ch0 at D = 5 and ch3 at D = 7, both mid-count; pulse sync together with cfg_we (ch3, D = 2) -> all count = 0, sq = 0; ch0 ticks 5 cycles later and ch3 2 cycles later. Dropping en[0] for 3 cycles delays ch0's next tick by exactly 3 cycles.
- Reset mid-operation: assert rst while ch1 has a pending write -> after release, div_active[ch1] = DEFAULT_DIV and the pending value is never applied.
